// File: rtl/regfile8_onehot_pkg.sv
// Shared MISC-V register-file definitions: sizes, default data width and
// the address / one-hot select types used by the register file and its checker.
package miscv_pkg;

  localparam int REG_COUNT     = 8;
  localparam int REG_ADDR_W    = 3;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ERR_CNT_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_sel_t;

endpackage

// File: rtl/regfile8_onehot_if.sv
// Bus bundle for regfile8_onehot: one-hot write port, two binary-addressed
// read ports and the illegal-select error reporting.
interface regfile8_onehot_if
  import miscv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
);

  logic                 we;
  reg_sel_t             wsel;
  logic [WIDTH-1:0]     wdata;

  logic                 re_a;
  reg_addr_t            raddr_a;
  logic                 re_b;
  reg_addr_t            raddr_b;

  logic [WIDTH-1:0]     rdata_a;
  logic                 rvalid_a;
  logic [WIDTH-1:0]     rdata_b;
  logic                 rvalid_b;

  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output we, wsel, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b,
    input  sel_err, err_cnt
  );

  modport slave (
    input  we, wsel, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b,
    output sel_err, err_cnt
  );

endinterface

// File: rtl/regfile8_onehot_onehot_check.sv
// Combinational one-hot qualifier for the decoder-driven write select:
// flags exactly-one-bit-set and encodes the selected bit position.
module onehot_check
  import miscv_pkg::*;
(
  input  reg_sel_t  sel,
  output logic      is_onehot,
  output reg_addr_t idx
);

  // A power of two has exactly one bit set; zero is excluded explicitly.
  always_comb begin
    is_onehot = (sel != '0) && ((sel & (sel - reg_sel_t'(1))) == '0);
  end

  // Index is only meaningful when is_onehot is high; the highest set bit wins otherwise.
  always_comb begin
    idx = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (sel[i]) idx = REG_ADDR_W'(i);
    end
  end

endmodule

// File: rtl/regfile8_onehot.sv
// 8-entry register file with one-hot write select, two registered read ports
// and sticky/saturating illegal-select reporting. Define MISCV_REGFILE_BYPASS_EN
// to forward same-cycle legal write data to a matching read.
module regfile8_onehot
  import miscv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
)(
  input  logic               CLK,
  input  logic               RST_N,
  regfile8_onehot_if.slave   bus
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [WIDTH-1:0]     regs [REG_COUNT];

  logic                 sel_ok;
  reg_addr_t            widx;
  logic                 wr_ok;
  logic                 wr_bad;

  logic [WIDTH-1:0]     rd_a_p0;
  logic [WIDTH-1:0]     rd_b_p0;

  logic [WIDTH-1:0]     rdata_a_p1;
  logic [WIDTH-1:0]     rdata_b_p1;
  logic                 vld_a_p1;
  logic                 vld_b_p1;
  logic                 sel_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  onehot_check u_onehot_check (
    .sel       (bus.wsel),
    .is_onehot (sel_ok),
    .idx       (widx)
  );

  // wsel is only qualified while we is high; an idle bus never raises an error.
  assign wr_ok  = bus.we &&  sel_ok;
  assign wr_bad = bus.we && !sel_ok;

  // Stage p0: array lookup (plus optional forwarding) for both read ports
  always_comb begin
    rd_a_p0 = regs[bus.raddr_a];
`ifdef MISCV_REGFILE_BYPASS_EN
    if (wr_ok && (widx == bus.raddr_a)) rd_a_p0 = bus.wdata;
`endif
  end

  always_comb begin
    rd_b_p0 = regs[bus.raddr_b];
`ifdef MISCV_REGFILE_BYPASS_EN
    if (wr_ok && (widx == bus.raddr_b)) rd_b_p0 = bus.wdata;
`endif
  end

  // Register array update
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[widx] <= bus.wdata;
    end
  end

  // Stage p1: registered read results; data holds when the port is idle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_a_p1 <= '0;
      vld_a_p1   <= 1'b0;
    end else begin
      vld_a_p1 <= bus.re_a;
      if (bus.re_a) rdata_a_p1 <= rd_a_p0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_b_p1 <= '0;
      vld_b_p1   <= 1'b0;
    end else begin
      vld_b_p1 <= bus.re_b;
      if (bus.re_b) rdata_b_p1 <= rd_b_p0;
    end
  end

  // Illegal-select bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (wr_bad) begin
      sel_err_q <= 1'b1;
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign bus.rdata_a  = rdata_a_p1;
  assign bus.rvalid_a = vld_a_p1;
  assign bus.rdata_b  = rdata_b_p1;
  assign bus.rvalid_b = vld_b_p1;
  assign bus.sel_err  = sel_err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_regfile8_onehot.sv
// Randomized and directed self-checking bench for regfile8_onehot against
// an array-based reference model of the register file.
module tb_regfile8_onehot;
  import miscv_pkg::*;

  localparam int W    = 16;
  localparam int ECW  = 4;
  localparam int EMAX = (1 << ECW) - 1;

  logic CLK;
  logic RST_N;

  regfile8_onehot_if #(.WIDTH(W), .ERR_CNT_W(ECW)) bus ();

  regfile8_onehot #(.WIDTH(W), .ERR_CNT_W(ECW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [W-1:0] mem [8];
  logic [W-1:0] exp_ra, exp_rb;
  logic         exp_va, exp_vb;
  logic         exp_err;
  int           exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    exp_ra = '0; exp_rb = '0; exp_va = 1'b0; exp_vb = 1'b0;
    exp_err = 1'b0; exp_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("rdata_a",  32'(bus.rdata_a),  32'(exp_ra));
    chk("rvalid_a", 32'(bus.rvalid_a), 32'(exp_va));
    chk("rdata_b",  32'(bus.rdata_b),  32'(exp_rb));
    chk("rvalid_b", 32'(bus.rvalid_b), 32'(exp_vb));
    chk("sel_err",  32'(bus.sel_err),  32'(exp_err));
    chk("err_cnt",  32'(bus.err_cnt),  32'(exp_cnt));
  endtask

  task automatic drive(input logic we, input logic [7:0] ws, input logic [W-1:0] wd,
                       input logic rea, input int ra, input logic reb, input int rb);
    bus.we      = we;
    bus.wsel    = ws;
    bus.wdata   = wd;
    bus.re_a    = rea;
    bus.raddr_a = reg_addr_t'(ra);
    bus.re_b    = reb;
    bus.raddr_b = reg_addr_t'(rb);
  endtask

  // One clock: apply the register-file rules to the inputs present at the edge.
  task automatic cycle();
    bit legal;
    int idx;
    @(posedge CLK);
    if (!RST_N) begin
      model_reset();
    end else begin
      legal = bus.we && ($countones(bus.wsel) == 1);
      idx = 0;
      for (int i = 0; i < 8; i++) if (bus.wsel[i]) idx = i;
      exp_va = bus.re_a;
      exp_vb = bus.re_b;
      if (bus.re_a) begin
        exp_ra = mem[bus.raddr_a];
`ifdef MISCV_REGFILE_BYPASS_EN
        if (legal && idx == int'(bus.raddr_a)) exp_ra = bus.wdata;
`endif
      end
      if (bus.re_b) begin
        exp_rb = mem[bus.raddr_b];
`ifdef MISCV_REGFILE_BYPASS_EN
        if (legal && idx == int'(bus.raddr_b)) exp_rb = bus.wdata;
`endif
      end
      if (legal) mem[idx] = bus.wdata;
      if (bus.we && !legal) begin
        exp_err = 1'b1;
        if (exp_cnt < EMAX) exp_cnt++;
      end
    end
    #1;
    check_outputs();
  endtask

  // Entered at posedge+1; leaves reset released at the following negedge.
  task automatic pulse_reset();
    drive(0, 8'h00, '0, 0, 0, 0, 0);
    RST_N = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) cycle();
    #4;
    RST_N = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, '0, 1, i, 1, i);
      cycle();
      chk("ports_agree", 32'(bus.rdata_a), 32'(bus.rdata_b));
    end
    drive(0, 8'h00, '0, 0, 0, 0, 0);
  endtask

  logic [7:0]   rws;
  logic [W-1:0] rwd;

  initial begin
    RST_N = 1'b1;
    drive(0, 8'h00, '0, 0, 0, 0, 0);
    model_reset();
    #1;
    RST_N = 1'b0;
    #1;
    check_outputs();
    repeat (2) cycle();
    #4;
    RST_N = 1'b1;

    // Every register reads zero after reset
    read_all();

    // Illegal select without we is ignored
    drive(0, 8'hFF, 16'h5555, 0, 0, 0, 0);
    cycle();
    drive(0, 8'h00, 16'h5555, 0, 0, 0, 0);
    cycle();
    chk("we0_no_err", 32'(bus.sel_err), 32'd0);

    // Single legal write then read
    drive(1, 8'b0000_0100, 16'hBEEF, 0, 0, 0, 0);
    cycle();
    drive(0, 8'h00, '0, 1, 2, 1, 3);
    cycle();
    chk("beef_a",  32'(bus.rdata_a),  32'h0000_BEEF);
    chk("beef_va", 32'(bus.rvalid_a), 32'd1);
    chk("reg3_b",  32'(bus.rdata_b),  32'd0);

    // Sweep every register
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(1 << i), W'(16'h1000 + i), 0, 0, 0, 0);
      cycle();
    end
    read_all();
    drive(0, 8'h00, '0, 1, 6, 1, 0);
    cycle();
    chk("sweep_r6", 32'(bus.rdata_a), 32'h1006);
    chk("sweep_r0", 32'(bus.rdata_b), 32'h1000);

    // Illegal selects: zero and multi-hot
    drive(1, 8'b0000_0000, 16'hDEAD, 0, 0, 0, 0);
    cycle();
    drive(1, 8'b0001_1000, 16'hDEAD, 0, 0, 0, 0);
    cycle();
    chk("err_set", 32'(bus.sel_err), 32'd1);
    chk("err_2",   32'(bus.err_cnt), 32'd2);
    read_all();
    for (int i = 0; i < 20; i++) begin
      drive(1, (i % 2 == 0) ? 8'hFF : 8'h81, 16'hDEAD, 0, 0, 0, 0);
      cycle();
    end
    chk("err_sat", 32'(bus.err_cnt), 32'd15);
    drive(0, 8'h00, '0, 1, 3, 1, 4);
    cycle();
    chk("r3_kept", 32'(bus.rdata_a), 32'h1003);
    chk("r4_kept", 32'(bus.rdata_b), 32'h1004);

    // Same-cycle read/write of register 5
    drive(1, 8'b0010_0000, 16'h0001, 0, 0, 0, 0);
    cycle();
    drive(1, 8'b0010_0000, 16'h0002, 1, 5, 1, 5);
    cycle();
`ifdef MISCV_REGFILE_BYPASS_EN
    chk("rw5_a", 32'(bus.rdata_a), 32'h0002);
    chk("rw5_b", 32'(bus.rdata_b), 32'h0002);
`else
    chk("rw5_a", 32'(bus.rdata_a), 32'h0001);
    chk("rw5_b", 32'(bus.rdata_b), 32'h0001);
`endif
    drive(0, 8'h00, '0, 1, 5, 0, 0);
    cycle();
    chk("rw5_next", 32'(bus.rdata_a), 32'h0002);

    // Fresh start, then randomized traffic
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) rws = 8'(1 << $urandom_range(0, 7));
      else                          rws = 8'($urandom);
      rwd = W'($urandom);
      drive(1'($urandom_range(0, 9) < 6), rws, rwd,
            1'($urandom), int'($urandom_range(0, 7)),
            1'($urandom), int'($urandom_range(0, 7)));
      cycle();
    end

    // Load a known value, then reset asynchronously with reads pending
    drive(1, 8'b1000_0000, 16'hA5A5, 0, 0, 0, 0);
    cycle();
    drive(1, 8'b0000_0011, 16'h0, 1, 7, 1, 7);
    cycle();
    chk("pre_rst_va", 32'(bus.rvalid_a), 32'd1);
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("async_va",  32'(bus.rvalid_a), 32'd0);
    chk("async_vb",  32'(bus.rvalid_b), 32'd0);
    chk("async_ra",  32'(bus.rdata_a),  32'd0);
    chk("async_err", 32'(bus.sel_err),  32'd0);
    chk("async_cnt", 32'(bus.err_cnt),  32'd0);
    cycle();
    #3;
    RST_N = 1'b1;
    read_all();
    drive(0, 8'h00, '0, 1, 7, 0, 0);
    cycle();
    chk("r7_cleared", 32'(bus.rdata_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile8_onehot.md
Name: regfile8_onehot

Overview:
- 8-entry general-purpose register file for the MISC-V datapath.
- Sits directly downstream of decoder3b8: it consumes the decoder's 8-bit one-hot output as the write-select vector.
- Two synchronous read ports with binary addresses and registered outputs.
- A sticky error flag reports any write whose select vector is not strictly one-hot.

Parameters:
- WIDTH, 16, data width of each register and of the read/write data ports.
- ERR_CNT_W, 4, width of the saturating illegal-select counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- we  input  1  write request this cycle.
- wsel  input  8  one-hot write select, taken directly from decoder3b8 out; bit i selects register i.
- wdata  input  WIDTH  write data.
- re_a  input  1  read request, port A.
- raddr_a  input  3  binary read address, port A.
- re_b  input  1  read request, port B.
- raddr_b  input  3  binary read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rvalid_a  output  1  rdata_a valid; a one-cycle pulse per request.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid_b  output  1  rdata_b valid.
- sel_err  output  1  sticky flag; set by an illegal write select.
- err_cnt  output  ERR_CNT_W  saturating count of illegal write attempts.

Behaviour:
- Reset (RST_N low, asynchronous):
  - all 8 registers = 0;
  - rdata_a = rdata_b = 0;
  - rvalid_a = rvalid_b = 0;
  - sel_err = 0;
  - err_cnt = 0.
- Reset asserted mid-operation clears all state immediately. A write or read in flight is discarded; no partial update.
- Write:
  - Condition: rising edge with we=1 and wsel exactly one-hot (popcount == 1).
  - Action: reg[i] <= wdata, where wsel[i]=1.
  - Effect: visible to reads issued from the next cycle onward, or the same cycle when bypass is compiled in.
- Illegal write: we=1 and wsel popcount != 1 (all-zero or multi-hot).
  - No register changes.
  - sel_err <= 1 and stays set until reset.
  - err_cnt increments by 1, saturating at 2^ERR_CNT_W - 1 with no wrap.
- we=0: wsel is ignored entirely. No error is raised, even if wsel is illegal.
- Read, port A (port B identical and independent):
  - Request cycle: re_a=1 captures raddr_a.
  - Next edge: rdata_a <= reg[raddr_a] and rvalid_a <= 1. Latency is exactly 1 cycle.
  - re_a=0: rvalid_a <= 0 and rdata_a holds its previous value.
- Both ports may read the same address in the same cycle; each returns the same data.
- Simultaneous read and write to the same register, without bypass: the read returns the old (pre-write) value.
- Back-to-back reads: one result per cycle per port, with no stalls.
- Register 0 is an ordinary writable register; there is no hardwired zero.

Optional Feature:
- Macro: MISCV_REGFILE_BYPASS_EN.
- Defined: a legal write in the same cycle as a read of the same register forwards wdata to that port's rdata on the next edge. Read-after-write therefore has zero bubble. Illegal writes never forward.
- Undefined: the read returns the old value, as stated above. There is no forwarding logic.

Decomposition:
- Shared package miscv_pkg holds:
  - REG_COUNT = 8;
  - REG_ADDR_W = 3;
  - a default WIDTH constant;
  - typedef reg_addr_t (3-bit);
  - typedef reg_sel_t (8-bit one-hot).
- One sub-module, onehot_check: purely combinational. Input reg_sel_t; outputs is_onehot and the 3-bit encoded index. The index also drives the bypass address compare.

Test Plan:
- Reset check: hold RST_N=0, then release. All outputs are 0. Read of every address 0..7 returns 0x0000 one cycle after re.
- Legal writes: drive wsel=8'b0000_0100 with wdata=16'hBEEF and we=1, then re_a=1, raddr_a=2. Next cycle rdata_a=16'hBEEF, rvalid_a=1. Register 3 still reads 0.
- Sweep: write 16'h1000+i through wsel=1<<i for i=0..7, then read all 8 on both ports. Values match; ports A and B agree.
- Illegal select:
  - Write wsel=8'b0000_0000 and 8'b0001_1000 with we=1. sel_err=1, err_cnt=2, and all registers are unchanged.
  - Then 20 further illegal writes: err_cnt saturates at 15.
  - Illegal wsel with we=0 produces no error.
- Same-cycle read/write of register 5: old value 16'h0001, write 16'h0002. Without MISCV_REGFILE_BYPASS_EN, rdata returns 16'h0001. With it, rdata returns 16'h0002. The following read returns 16'h0002 in both builds.
- Asynchronous reset mid-stream: assert RST_N=0 between clock edges while reads are pending. rvalid_a, rvalid_b and the registers clear immediately, without waiting for CLK.
